// File: rtl/mc_timer_pkg.sv
// ---------------------------------------------------------------------------
// mc_timer_pkg
// Shared definitions for the multi-channel interval timer.
//   regSel_e          : register offsets within one channel's 8-word window
//   CTRL_* constants  : bit positions inside the CONTROL register
//   STATUS_* constants: bit positions inside the STATUS register
// No ports (package).
// ---------------------------------------------------------------------------
package mc_timer_pkg;

  // Register offsets inside a channel window; offsets 5..7 are reserved.
  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_SNAPSHOT = 3'd3,
    REG_PRESCALE = 3'd4
  } regSel_e;

  // CONTROL bits: ITO/CONT are stored, START/STOP are write-only strobes.
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // STATUS bits.
  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

endpackage

// File: rtl/mc_timer_channel.sv
// ---------------------------------------------------------------------------
// mc_timer_channel
// One independent interval-timer channel: period, prescaler, control bits,
// down-counter, snapshot, timeout flag and run flag.
// Ports:
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset
//   wrEn_i     : bus write aimed at this channel this cycle
//   regSel_i   : register offset within the channel window
//   wdata_i    : bus write data
//   rdata_o    : combinational read word for the selected register
//   irq_o      : TO & ITO
// ---------------------------------------------------------------------------
module mc_timer_channel
  import mc_timer_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int COUNTER_W    = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wrEn_i,
  input  logic [2:0]        regSel_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              irq_o
);

  localparam logic [COUNTER_W-1:0] RESET_VAL = COUNTER_W'(RESET_PERIOD);

  logic [COUNTER_W-1:0]  period_q, period_d;
  logic [COUNTER_W-1:0]  counter_q, counter_d;
  logic [COUNTER_W-1:0]  snapshot_q, snapshot_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pscnt_q, pscnt_d;
  logic                  ito_q, ito_d;
  logic                  cont_q, cont_d;
  logic                  run_q, run_d;
  logic                  to_q, to_d;
  logic                  reloadPending_q, reloadPending_d;

  logic wrStatus, wrControl, wrPeriod, wrSnapshot, wrPrescale;
  logic startStrobe, stopStrobe;
  logic tick, timeoutEvent;
  logic unusedWdata;

  // Write data above each field's width is deliberately dropped.
  assign unusedWdata = ^wdata_i;

  // Decode which register this cycle's write targets.
  always_comb begin
    wrStatus   = 1'b0;
    wrControl  = 1'b0;
    wrPeriod   = 1'b0;
    wrSnapshot = 1'b0;
    wrPrescale = 1'b0;
    if (wrEn_i) begin
      case (regSel_i)
        REG_STATUS:   wrStatus   = 1'b1;
        REG_CONTROL:  wrControl  = 1'b1;
        REG_PERIOD:   wrPeriod   = 1'b1;
        REG_SNAPSHOT: wrSnapshot = 1'b1;
        REG_PRESCALE: wrPrescale = 1'b1;
        default:      ;
      endcase
    end
  end

  assign startStrobe  = wrControl & wdata_i[CTRL_START];
  assign stopStrobe   = wrControl & wdata_i[CTRL_STOP];
  assign tick         = run_q && (pscnt_q == prescale_q);
  assign timeoutEvent = tick && (counter_q == '0);

  // Next-state logic. Assignments are ordered so that later ones take
  // priority: START beats STOP, timeout beats a STATUS clear, and the
  // pending reload after a PERIOD write overrides everything touching
  // the counter, prescaler count and run flag.
  always_comb begin
    period_d        = period_q;
    prescale_d      = prescale_q;
    ito_d           = ito_q;
    cont_d          = cont_q;
    run_d           = run_q;
    to_d            = to_q;
    counter_d       = counter_q;
    pscnt_d         = pscnt_q;
    snapshot_d      = snapshot_q;
    reloadPending_d = wrPeriod;

    if (wrPeriod)   period_d   = wdata_i[COUNTER_W-1:0];
    if (wrPrescale) prescale_d = wdata_i[PRESCALE_W-1:0];
    if (wrControl) begin
      ito_d  = wdata_i[CTRL_ITO];
      cont_d = wdata_i[CTRL_CONT];
    end
    if (wrSnapshot) snapshot_d = counter_q;

    if (run_q) pscnt_d = tick ? '0 : pscnt_q + PRESCALE_W'(1);

    if (tick) begin
      if (timeoutEvent) begin
        counter_d = period_q;
        if (!cont_q) run_d = 1'b0;
      end else begin
        counter_d = counter_q - COUNTER_W'(1);
      end
    end

    if (stopStrobe)  run_d = 1'b0;
    if (startStrobe) run_d = 1'b1;

    if (wrStatus)     to_d = 1'b0;
    if (timeoutEvent) to_d = 1'b1;

    if (reloadPending_q) begin
      counter_d = period_q;
      pscnt_d   = '0;
      run_d     = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      period_q        <= RESET_VAL;
      counter_q       <= RESET_VAL;
      snapshot_q      <= '0;
      prescale_q      <= '0;
      pscnt_q         <= '0;
      ito_q           <= 1'b0;
      cont_q          <= 1'b0;
      run_q           <= 1'b0;
      to_q            <= 1'b0;
      reloadPending_q <= 1'b0;
    end else begin
      period_q        <= period_d;
      counter_q       <= counter_d;
      snapshot_q      <= snapshot_d;
      prescale_q      <= prescale_d;
      pscnt_q         <= pscnt_d;
      ito_q           <= ito_d;
      cont_q          <= cont_d;
      run_q           <= run_d;
      to_q            <= to_d;
      reloadPending_q <= reloadPending_d;
    end
  end

  // Read word for the selected register; reserved offsets read zero.
  always_comb begin
    rdata_o = '0;
    case (regSel_i)
      REG_STATUS: begin
        rdata_o[STATUS_RUN] = run_q;
        rdata_o[STATUS_TO]  = to_q;
      end
      REG_CONTROL: begin
        rdata_o[CTRL_CONT] = cont_q;
        rdata_o[CTRL_ITO]  = ito_q;
      end
      REG_PERIOD:   rdata_o[COUNTER_W-1:0]  = period_q;
      REG_SNAPSHOT: rdata_o[COUNTER_W-1:0]  = snapshot_q;
      REG_PRESCALE: rdata_o[PRESCALE_W-1:0] = prescale_q;
      default:      ;
    endcase
  end

  assign irq_o = to_q & ito_q;

endmodule

// File: rtl/multi_channel_interval_timer.sv
// ---------------------------------------------------------------------------
// multi_channel_interval_timer
// N-channel interval timer on an Avalon-MM slave.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   address    : {channel, reg[2:0]}
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (latency 1)
//   irq        : OR of irq_vec
//   irq_vec    : per-channel TO & ITO
// ---------------------------------------------------------------------------
module multi_channel_interval_timer
  import mc_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 32,
  parameter int COUNTER_W    = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 49999,
  localparam int ADDR_W      = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  logic [ADDR_W-1:0] chSel;
  logic [2:0]        regSel;
  logic              busWrite;
  logic [DATA_W-1:0] chRdata [NUM_CH];
  logic [DATA_W-1:0] readdata_d, readdata_q;

  // A shift keeps the channel field well-formed even when NUM_CH is 1.
  assign chSel    = address >> 3;
  assign regSel   = address[2:0];
  assign busWrite = chipselect & ~write_n;

  // One channel per index; a channel only sees writes addressed to it, so
  // channel indices at or above NUM_CH hit nothing.
  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    mc_timer_channel #(
      .DATA_W      (DATA_W),
      .COUNTER_W   (COUNTER_W),
      .PRESCALE_W  (PRESCALE_W),
      .RESET_PERIOD(RESET_PERIOD)
    ) uChannel (
      .clk_i   (clk),
      .reset_i (reset),
      .wrEn_i  (busWrite && (chSel == ADDR_W'(g))),
      .regSel_i(regSel),
      .wdata_i (writedata),
      .rdata_o (chRdata[g]),
      .irq_o   (irq_vec[g])
    );
  end

  // Channel read mux; out-of-range channels fall through to zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chSel == ADDR_W'(i)) readdata_d = chRdata[i];
    end
  end

  // Readdata is refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_interval_timer
// Directed bench for the multi-channel interval timer, built with three
// channels so that channel index 3 is addressable but out of range, and a
// 16-bit counter so that ignored high write-data bits are visible.
// ---------------------------------------------------------------------------
module tb_multi_channel_interval_timer;

  localparam int NUM_CH     = 3;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int COUNTER_W  = 16;
  localparam int PRESCALE_W = 8;

  localparam int R_STATUS   = 0;
  localparam int R_CONTROL  = 1;
  localparam int R_PERIOD   = 2;
  localparam int R_SNAPSHOT = 3;
  localparam int R_PRESCALE = 4;
  localparam int R_RSVD5    = 5;

  typedef struct {
    bit          isWrite;
    int          ch;
    int          regSel;
    logic [31:0] data;
    logic [31:0] expData;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  int totalChecks = 0;
  int badChecks   = 0;
  vec_t vecs [16];

  multi_channel_interval_timer #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .COUNTER_W   (COUNTER_W),
    .PRESCALE_W  (PRESCALE_W),
    .RESET_PERIOD(49999)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .irq_vec   (irq_vec)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // All bus tasks start and end on a falling edge, one rising edge each.
  task automatic busWrite(input int ch, input int r, input logic [31:0] data);
    address    = ADDR_W'(ch * 8 + r);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic busRead(input int ch, input int r, output logic [31:0] data);
    address    = ADDR_W'(ch * 8 + r);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    data       = readdata;
    chipselect = 1'b0;
  endtask

  task automatic readCheck(input string name, input int ch, input int r,
                           input logic [31:0] expected);
    logic [31:0] got;
    busRead(ch, r, got);
    checkOutput(name, got, expected);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count falling edges until the channel's irq_vec bit rises (bounded).
  task automatic waitIrq(input string name, input int ch, input int expCycles);
    int cycles;
    cycles = 0;
    while (irq_vec[ch] !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(name, 32'(cycles), 32'(expCycles));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    if (v.isWrite) begin
      busWrite(v.ch, v.regSel, v.data);
    end else begin
      readCheck($sformatf("vec%0d", idx), v.ch, v.regSel, v.expData);
      checkOutput($sformatf("vec%0d_irq", idx), 32'(irq), 32'd0);
    end
  endtask

  initial begin
    // Register-access vectors: reset values, field truncation, reserved space.
    vecs[0]  = '{1'b0, 0, R_PERIOD,   32'h0,        32'd49999};
    vecs[1]  = '{1'b0, 0, R_STATUS,   32'h0,        32'd0};
    vecs[2]  = '{1'b0, 0, R_CONTROL,  32'h0,        32'd0};
    vecs[3]  = '{1'b0, 2, R_SNAPSHOT, 32'h0,        32'd0};
    vecs[4]  = '{1'b0, 1, R_PRESCALE, 32'h0,        32'd0};
    vecs[5]  = '{1'b1, 1, R_PRESCALE, 32'hFFFFFF07, 32'd0};
    vecs[6]  = '{1'b0, 1, R_PRESCALE, 32'h0,        32'd7};
    vecs[7]  = '{1'b1, 1, R_CONTROL,  32'h3,        32'd0};
    vecs[8]  = '{1'b0, 1, R_CONTROL,  32'h0,        32'd3};
    vecs[9]  = '{1'b1, 1, R_PERIOD,   32'hFFFF0009, 32'd0};
    vecs[10] = '{1'b0, 1, R_PERIOD,   32'h0,        32'd9};
    vecs[11] = '{1'b1, 1, R_RSVD5,    32'hFFFFFFFF, 32'd0};
    vecs[12] = '{1'b0, 1, R_RSVD5,    32'h0,        32'd0};
    vecs[13] = '{1'b0, 1, R_STATUS,   32'h0,        32'd0};
    vecs[14] = '{1'b1, 1, R_CONTROL,  32'h1,        32'd0};
    vecs[15] = '{1'b0, 1, R_CONTROL,  32'h0,        32'd1};

    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_irqVec", 32'(irq_vec), 32'd0);

    for (int i = 0; i < 16; i++) applyStimulus(i, vecs[i]);

    // One-shot: period 9, prescale 0 -> timeout exactly 10 clocks after START.
    $display("[TB] one-shot timeout on ch1");
    busWrite(1, R_PRESCALE, 32'd0);
    busWrite(1, R_CONTROL, 32'h5);
    waitIrq("oneshot_latency", 1, 10);
    checkOutput("oneshot_irq", 32'(irq), 32'd1);
    checkOutput("oneshot_irqVec", 32'(irq_vec), 32'b010);
    readCheck("oneshot_status", 1, R_STATUS, 32'h1);
    busWrite(1, R_STATUS, 32'h0);
    checkOutput("oneshot_clear_irq", 32'(irq), 32'd0);

    // Continuous: period 3, prescale 4 -> timeout every 20 clocks.
    $display("[TB] continuous mode on ch2");
    busWrite(2, R_PERIOD, 32'd3);
    busWrite(2, R_PRESCALE, 32'd4);
    busWrite(2, R_CONTROL, 32'h7);
    waitIrq("cont_first", 2, 20);
    busWrite(2, R_STATUS, 32'h0);
    waitIrq("cont_second", 2, 19);
    readCheck("cont_status", 2, R_STATUS, 32'h3);

    // STATUS clear landing on the same edge as a timeout leaves TO set.
    busWrite(2, R_STATUS, 32'h0);
    idle(17);
    busWrite(2, R_STATUS, 32'h0);
    checkOutput("collide_irqVec", 32'(irq_vec), 32'b100);
    readCheck("collide_status", 2, R_STATUS, 32'h3);

    // STOP alone stops; STOP|START together restarts.
    busWrite(2, R_CONTROL, 32'h8);
    readCheck("stop_status", 2, R_STATUS, 32'h1);
    busWrite(2, R_STATUS, 32'h0);
    busWrite(2, R_CONTROL, 32'hC);
    readCheck("startwins_status", 2, R_STATUS, 32'h2);
    checkOutput("startwins_irq", 32'(irq), 32'd0);
    busWrite(2, R_CONTROL, 32'h8);

    // Snapshot and period-write reload on ch0.
    $display("[TB] snapshot and reload on ch0");
    busWrite(0, R_PERIOD, 32'd100);
    busWrite(0, R_CONTROL, 32'h4);
    readCheck("reload_beats_start", 0, R_STATUS, 32'h0);
    busWrite(0, R_CONTROL, 32'h4);
    idle(10);
    busWrite(0, R_SNAPSHOT, 32'h0);
    readCheck("snapshot_90", 0, R_SNAPSHOT, 32'd90);
    busWrite(0, R_PERIOD, 32'd100);
    idle(1);
    readCheck("period_write_stops", 0, R_STATUS, 32'h0);
    busWrite(0, R_SNAPSHOT, 32'h0);
    readCheck("snapshot_reloaded", 0, R_SNAPSHOT, 32'd100);

    // Out-of-range channel: no aliasing, reads zero.
    $display("[TB] out-of-range channel");
    busWrite(3, R_PERIOD, 32'h1234);
    busWrite(3, R_CONTROL, 32'h5);
    readCheck("oor_period", 3, R_PERIOD, 32'd0);
    readCheck("oor_ch0_period", 0, R_PERIOD, 32'd100);
    readCheck("oor_ch1_period", 1, R_PERIOD, 32'd9);
    readCheck("oor_ch2_period", 2, R_PERIOD, 32'd3);
    readCheck("oor_ch0_status", 0, R_STATUS, 32'h0);
    readCheck("oor_ch1_status", 1, R_STATUS, 32'h0);

    // Reset while ch1 is counting.
    $display("[TB] reset mid-count");
    busWrite(1, R_CONTROL, 32'h5);
    idle(5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_readdata", readdata, 32'd0);
    checkOutput("midreset_irq", 32'(irq), 32'd0);
    readCheck("midreset_ch1_period", 1, R_PERIOD, 32'd49999);
    readCheck("midreset_ch1_control", 1, R_CONTROL, 32'd0);
    readCheck("midreset_ch1_status", 1, R_STATUS, 32'd0);
    readCheck("midreset_ch0_period", 0, R_PERIOD, 32'd49999);
    readCheck("midreset_ch0_snapshot", 0, R_SNAPSHOT, 32'd0);
    readCheck("midreset_ch2_prescale", 2, R_PRESCALE, 32'd0);
    idle(30);
    checkOutput("midreset_no_irq", 32'(irq), 32'd0);
    readCheck("midreset_ch1_status_late", 1, R_STATUS, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
